// File: rtl/jac_core_mc.sv
// Multi-cycle JAC core: FETCH/EXEC/OUT/HALT sequencer around PC, register file,
// ALU with Z/C flags, handshaked instruction fetch and a valid/ready output port.
module jac_core_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2,
    parameter int PC_WIDTH   = 8,
    parameter int IR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  sys_res,
    input  logic                  run,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic [IR_WIDTH-1:0]   imem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  halted,
    output logic                  err
);
    localparam int NREG = 2 ** SEL_WIDTH;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_MOV  = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_JMP  = 5'd9;
    localparam logic [4:0] OP_JZ   = 5'd10;
    localparam logic [4:0] OP_JC   = 5'd11;
    localparam logic [4:0] OP_OUT  = 5'd12;
    localparam logic [4:0] OP_HALT = 5'd13;

    logic [1:0]            state;
    logic [IR_WIDTH-1:0]   ir;
    logic [DATA_WIDTH-1:0] regs [NREG];

    logic [4:0]            op;
    logic [SEL_WIDTH-1:0]  rd, rs;
    logic [DATA_WIDTH-1:0] imm, a, b;

    // rs and imm share low instruction bits; each opcode consumes only one.
    assign op  = ir[IR_WIDTH-1 -: 5];
    assign rd  = ir[IR_WIDTH-6 -: SEL_WIDTH];
    assign rs  = ir[IR_WIDTH-6-SEL_WIDTH -: SEL_WIDTH];
    assign imm = ir[DATA_WIDTH-1:0];
    assign a   = regs[rd];
    assign b   = regs[rs];

    assign imem_req  = (state == S_FETCH) && run;
    assign imem_addr = pc;

    logic [DATA_WIDTH:0]   wide;
    logic [DATA_WIDTH-1:0] res;
    logic                  wr_en, upd_flags, jump;

    // Carry/borrow comes from the extra top bit of wide; logic ops leave it 0.
    always_comb begin
        wide      = '0;
        res       = '0;
        wr_en     = 1'b0;
        upd_flags = 1'b0;
        jump      = 1'b0;
        case (op)
            OP_LDI:  begin res = imm; wr_en = 1'b1; end
            OP_MOV:  begin res = b;   wr_en = 1'b1; end
            OP_ADD:  begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[DATA_WIDTH-1:0]; wr_en = 1'b1; upd_flags = 1'b1;
            end
            OP_SUB:  begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[DATA_WIDTH-1:0]; wr_en = 1'b1; upd_flags = 1'b1;
            end
            OP_AND:  begin res = a & b; wr_en = 1'b1; upd_flags = 1'b1; end
            OP_OR:   begin res = a | b; wr_en = 1'b1; upd_flags = 1'b1; end
            OP_XOR:  begin res = a ^ b; wr_en = 1'b1; upd_flags = 1'b1; end
            OP_ADDI: begin
                wide = {1'b0, a} + {1'b0, imm};
                res  = wide[DATA_WIDTH-1:0]; wr_en = 1'b1; upd_flags = 1'b1;
            end
            OP_JMP:  jump = 1'b1;
            OP_JZ:   jump = flag_z;
            OP_JC:   jump = flag_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge sys_res) begin
        if (sys_res) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (run && imem_ready) begin
                    ir    <= imem_data;
                    pc    <= pc + PC_WIDTH'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    if (wr_en) regs[rd] <= res;
                    if (upd_flags) begin
                        flag_z <= (res == '0);
                        flag_c <= wide[DATA_WIDTH];
                    end
                    // Taken jump overrides the pc already advanced in FETCH.
                    if (jump) pc <= imm[PC_WIDTH-1:0];
                    if (op == OP_OUT) begin
                        out_data  <= a;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (op > OP_HALT) begin
                        err    <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end
                end
                S_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jac_core_mc.sv
// Directed bench for jac_core_mc: small programs in a behavioural instruction
// memory, hand-computed OUT streams, flags, pc and handshake behaviour.
module tb_jac_core_mc;
    logic        clk = 1'b0;
    logic        sys_res, run, imem_ready, out_ready;
    logic        imem_req, out_valid, flag_z, flag_c, halted, err;
    logic [7:0]  imem_addr, out_data, pc;
    logic [15:0] imem_data;

    jac_core_mc dut (
        .clk(clk), .sys_res(sys_res), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_data(imem_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .pc(pc), .flag_z(flag_z), .flag_c(flag_c),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr];

    int         checks = 0, failures = 0;
    logic [7:0] outq [$];
    int         xfers, vcyc, wcnt;
    bit         wait_mode, stab_en, pend;
    logic [7:0] pend_addr;

    localparam logic [4:0] LDI = 1, MOV = 2, ADD = 3, SUB = 4, AND_ = 5, OR_ = 6,
                           XOR_ = 7, ADDI = 8, JMP = 9, JZ = 10, JC = 11, OUT = 12, HLT = 13;

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, 9'b0} | {7'b0, rs, 7'b0} | {8'b0, imm};
    endfunction

    // Output transfer monitor plus fetch-address stability while a request waits.
    always @(posedge clk) begin
        if (!sys_res) begin
            if (out_valid) vcyc++;
            if (out_valid && out_ready) begin outq.push_back(out_data); xfers++; end
            if (stab_en && pend) begin
                checks++;
                if (imem_addr !== pend_addr) begin failures++; $display("FAIL addr_stable got=%h exp=%h", imem_addr, pend_addr); end
            end
            pend      = imem_req && !imem_ready;
            pend_addr = imem_addr;
        end
    end

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(HLT, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 sys_res = 1'b1; #1;
        checks++;
        if ({pc, flag_z, flag_c, halted, err, out_valid, out_data} !== 21'd0) begin
            failures++; $display("FAIL reset_async got=%h exp=0", {pc, flag_z, flag_c, halted, err, out_valid, out_data});
        end
        @(negedge clk); sys_res = 1'b0;
        outq.delete(); xfers = 0; vcyc = 0; pend = 0;
    endtask

    task automatic run_until_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            if (wait_mode) begin
                run = ($urandom_range(0, 3) != 0);
                if (wcnt == 0) begin imem_ready = 1'b1; wcnt = $urandom_range(0, 3); end
                else begin imem_ready = 1'b0; wcnt--; end
            end
            @(posedge clk); cyc++; @(negedge clk);
        end
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_timeout got=%b exp=1", halted); end
    endtask

    task automatic test_reset();
        sys_res = 1'b1; run = 1'b0; imem_ready = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pc, flag_z, flag_c, halted, err, out_valid, out_data, imem_req} !== 22'd0) begin
            failures++; $display("FAIL reset_state got=%h exp=0", {pc, flag_z, flag_c, halted, err, out_valid, out_data, imem_req});
        end
        sys_res = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || pc !== 8'd0) begin failures++; $display("FAIL run_low_idle req=%b pc=%h exp req=0 pc=0", imem_req, pc); end
    endtask

    task automatic test_arith();
        int cyc;
        clr_mem();
        mem[0] = enc(LDI, 0, 0, 8'd5); mem[1] = enc(LDI, 1, 0, 8'd3);
        mem[2] = enc(ADD, 0, 1, 0);    mem[3] = enc(OUT, 0, 0, 0);
        do_reset(); run = 1'b1;
        run_until_halt(100, cyc);
        checks++; if (cyc !== 11) begin failures++; $display("FAIL arith_cycles got=%0d exp=11", cyc); end
        checks++; if (outq.size() != 1 || outq[0] !== 8'd8) begin failures++; $display("FAIL arith_out got=%p exp=8", outq); end
        checks++; if (vcyc !== 1) begin failures++; $display("FAIL arith_valid_len got=%0d exp=1", vcyc); end
        checks++; if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL arith_flags got=%b exp=00", {flag_z, flag_c}); end
        repeat (3) @(negedge clk);
        checks++; if (pc !== 8'd5 || imem_req !== 1'b0) begin failures++; $display("FAIL arith_halt pc=%h req=%b exp pc=05 req=0", pc, imem_req); end
    endtask

    task automatic test_carry();
        int cyc;
        clr_mem();
        mem[0] = enc(LDI, 0, 0, 8'hFF); mem[1] = enc(ADDI, 0, 0, 8'd1); mem[2] = enc(OUT, 0, 0, 0);
        do_reset(); run = 1'b1;
        run_until_halt(100, cyc);
        checks++; if (outq.size() != 1 || outq[0] !== 8'h00) begin failures++; $display("FAIL carry_out got=%p exp=0", outq); end
        checks++; if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL carry_flags got=%b exp=11", {flag_z, flag_c}); end
        mem[2] = enc(LDI, 1, 0, 8'd1); mem[3] = enc(SUB, 0, 1, 0); mem[4] = enc(OUT, 0, 0, 0);
        do_reset();
        run_until_halt(100, cyc);
        checks++; if (outq.size() != 1 || outq[0] !== 8'hFF) begin failures++; $display("FAIL borrow_out got=%p exp=ff", outq); end
        checks++; if ({flag_z, flag_c} !== 2'b01) begin failures++; $display("FAIL borrow_flags got=%b exp=01", {flag_z, flag_c}); end
    endtask

    task automatic test_logic_jumps();
        int cyc;
        clr_mem();
        mem[0]  = enc(LDI, 0, 0, 8'hF0); mem[1]  = enc(LDI, 1, 0, 8'h3C);
        mem[2]  = enc(MOV, 2, 0, 0);     mem[3]  = enc(AND_, 2, 1, 0);
        mem[4]  = enc(OUT, 2, 0, 0);     mem[5]  = enc(MOV, 2, 0, 0);
        mem[6]  = enc(OR_, 2, 1, 0);     mem[7]  = enc(OUT, 2, 0, 0);
        mem[8]  = enc(XOR_, 0, 1, 0);    mem[9]  = enc(OUT, 0, 0, 0);
        mem[10] = enc(XOR_, 0, 0, 0);    mem[11] = enc(JC, 0, 0, 8'd13);
        mem[12] = enc(JZ, 0, 0, 8'd14);  mem[13] = enc(OUT, 1, 0, 0);
        do_reset(); run = 1'b1;
        run_until_halt(200, cyc);
        checks++;
        if (outq.size() != 3 || outq[0] !== 8'h30 || outq[1] !== 8'hFC || outq[2] !== 8'hCC) begin
            failures++; $display("FAIL logic_out got=%p exp=30 fc cc", outq);
        end
        checks++; if ({flag_z, flag_c} !== 2'b10) begin failures++; $display("FAIL logic_flags got=%b exp=10", {flag_z, flag_c}); end
        checks++; if (pc !== 8'd15) begin failures++; $display("FAIL jump_pc got=%h exp=0f", pc); end
    endtask

    task automatic load_loop();
        clr_mem();
        mem[0] = enc(LDI, 0, 0, 8'd3); mem[1] = enc(LDI, 1, 0, 8'd1);
        mem[2] = enc(OUT, 0, 0, 0);    mem[3] = enc(SUB, 0, 1, 0);
        mem[4] = enc(JZ, 0, 0, 8'd6);  mem[5] = enc(JMP, 0, 0, 8'd2);
    endtask

    task automatic check_loop(input string tag);
        checks++;
        if (outq.size() != 3 || outq[0] !== 8'd3 || outq[1] !== 8'd2 || outq[2] !== 8'd1) begin
            failures++; $display("FAIL %s_out got=%p exp=3 2 1", tag, outq);
        end
        checks++;
        if ({pc, flag_z, flag_c} !== {8'd7, 2'b10}) begin
            failures++; $display("FAIL %s_state got pc=%h zc=%b exp pc=07 zc=10", tag, pc, {flag_z, flag_c});
        end
    endtask

    task automatic test_loop();
        int cyc;
        load_loop(); do_reset(); run = 1'b1;
        run_until_halt(300, cyc);
        check_loop("loop");
    endtask

    task automatic test_wait_states();
        int cyc;
        load_loop(); do_reset();
        wait_mode = 1'b1; stab_en = 1'b1; wcnt = 0;
        run_until_halt(3000, cyc);
        wait_mode = 1'b0; stab_en = 1'b0; run = 1'b1; imem_ready = 1'b1;
        check_loop("wait");
    endtask

    task automatic test_run_gating();
        int cyc;
        clr_mem();
        mem[0] = enc(LDI, 3, 0, 8'h42); mem[1] = enc(OUT, 3, 0, 0);
        do_reset();
        run = 1'b1; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin failures++; $display("FAIL gate_pending req=%b addr=%h exp req=1 addr=00", imem_req, imem_addr); end
        run = 1'b0; imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0 || pc !== 8'd0) begin failures++; $display("FAIL gate_no_latch req=%b pc=%h exp req=0 pc=00", imem_req, pc); end
        run = 1'b1;
        @(negedge clk);
        checks++; if (pc !== 8'd1 || imem_req !== 1'b0) begin failures++; $display("FAIL gate_resume pc=%h req=%b exp pc=01 req=0", pc, imem_req); end
        run_until_halt(100, cyc);
        checks++; if (outq.size() != 1 || outq[0] !== 8'h42) begin failures++; $display("FAIL gate_out got=%p exp=42", outq); end
    endtask

    task automatic test_backpressure();
        int cyc, n;
        clr_mem();
        mem[0] = enc(LDI, 2, 0, 8'h5A); mem[1] = enc(OUT, 2, 0, 0);
        do_reset(); run = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_data, imem_req} !== {1'b1, 8'h5A, 1'b0}) begin
                failures++; $display("FAIL bp_hold%0d got v=%b d=%h req=%b exp v=1 d=5a req=0", i, out_valid, out_data, imem_req);
            end
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        run_until_halt(100, cyc);
        checks++; if (xfers !== 1 || outq.size() != 1 || outq[0] !== 8'h5A) begin failures++; $display("FAIL bp_xfer got n=%0d q=%p exp n=1 q=5a", xfers, outq); end
        checks++; if (pc !== 8'd3) begin failures++; $display("FAIL bp_pc got=%h exp=03", pc); end
    endtask

    task automatic test_illegal();
        clr_mem();
        mem[0] = enc(LDI, 0, 0, 8'd7); mem[1] = enc(5'd20, 0, 0, 0);
        do_reset(); run = 1'b1;
        repeat (3) @(posedge clk); @(negedge clk);
        checks++; if ({err, halted} !== 2'b00) begin failures++; $display("FAIL ill_before got=%b exp=00", {err, halted}); end
        @(posedge clk); @(negedge clk);
        checks++; if ({err, halted, imem_req} !== 3'b110) begin failures++; $display("FAIL ill_trap got=%b exp=110", {err, halted, imem_req}); end
        do_reset();
        checks++; if ({pc, err, halted, imem_req} !== {8'd0, 3'b001}) begin failures++; $display("FAIL ill_restart got=%h exp=001", {pc, err, halted, imem_req}); end
    endtask

    task automatic test_reset_mid_out();
        int cyc, n;
        clr_mem();
        mem[0] = enc(LDI, 3, 0, 8'h11); mem[1] = enc(OUT, 3, 0, 0);
        do_reset(); run = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_out_reach got=%b exp=1", out_valid); end
        do_reset();
        out_ready = 1'b1;
        run_until_halt(100, cyc);
        checks++; if (outq.size() != 1 || outq[0] !== 8'h11 || pc !== 8'd3) begin failures++; $display("FAIL mid_out_restart q=%p pc=%h exp q=11 pc=03", outq, pc); end
    endtask

    initial begin
        wait_mode = 1'b0; stab_en = 1'b0; pend = 1'b0; wcnt = 0; xfers = 0; vcyc = 0;
        clr_mem();
        test_reset();
        test_arith();
        test_carry();
        test_logic_jumps();
        test_loop();
        test_wait_states();
        test_run_gating();
        test_backpressure();
        test_illegal();
        test_reset_mid_out();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jac_core_mc.md
Name: jac_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle JAC1 datapath.
- Integrates the program counter, decoder, register file, ALU and write-back mux behind one FETCH/EXEC/OUT state machine.
- Adds the following, which the first generation lacks:
  - an instruction-memory handshake with wait states;
  - Z/C flags with conditional jumps;
  - an output port with valid/ready backpressure;
  - run gating, HALT and illegal-opcode trapping.

Parameters:
- DATA_WIDTH, 8, register/ALU/immediate width.
- SEL_WIDTH, 2, register select bits; register file holds 2**SEL_WIDTH registers.
- PC_WIDTH, 8, program counter width; must be <= DATA_WIDTH.
- IR_WIDTH, 16, instruction width; must be >= 5+SEL_WIDTH+DATA_WIDTH and >= 5+2*SEL_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- sys_res  input  1  reset, asynchronous, active-high.
- run  input  1  fetch enable; sampled only in FETCH.
- imem_req  output  1  fetch request; high when state==FETCH and run==1.
- imem_addr  output  PC_WIDTH  fetch address; equals pc.
- imem_ready  input  1  memory has imem_data valid this cycle.
- imem_data  input  IR_WIDTH  instruction word.
- out_data  output  DATA_WIDTH  OUT payload.
- out_valid  output  1  OUT payload valid.
- out_ready  input  1  consumer accepts out_data.
- pc  output  PC_WIDTH  current program counter.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry/borrow flag.
- halted  output  1  core is in HALT.
- err  output  1  sticky illegal-opcode flag.

Behaviour:
- Reset (async, sys_res=1):
  - state=FETCH; pc, all registers, flags, ir, out_data, out_valid, halted and err all go to 0.
  - Takes effect mid-fetch and mid-OUT; no partial write-back survives.
- Instruction fields:
  - op = ir[IR_WIDTH-1 -: 5]
  - rd = next SEL_WIDTH bits
  - rs = next SEL_WIDTH bits
  - imm = ir[DATA_WIDTH-1:0]
  - rs and imm may overlap; each opcode reads only one of them.
- FETCH state:
  - imem_req = run.
  - On a cycle with run & imem_ready: latch ir = imem_data, pc <= pc+1 (modulo 2**PC_WIDTH, so all-ones wraps to 0), go to EXEC.
  - Otherwise hold; any number of wait states is allowed.
  - If run drops while a request is pending, the request is withdrawn and nothing is latched.
- EXEC state: one cycle; write-back and flags update at the end of the cycle; next state is FETCH unless stated below. Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 MOV: rd=rs.
  - 3 ADD: rd=rd+rs; C=carry-out.
  - 4 SUB: rd=rd-rs; C=borrow (rd<rs unsigned).
  - 5 AND, 6 OR, 7 XOR: rd=rd op rs; C=0.
  - 8 ADDI: rd=rd+imm; C=carry-out.
  - 9 JMP: pc=imm[PC_WIDTH-1:0].
  - 10 JZ: jump if Z=1.
  - 11 JC: jump if C=1.
  - 12 OUT: out_data<=rd, out_valid<=1, go to OUT.
  - 13 HALT: go to HALT.
  - 14-31: illegal; err<=1, go to HALT.
- Flags:
  - Z is updated by opcodes 3-8 only: Z = (DATA_WIDTH-bit result == 0).
  - LDI, MOV, jumps and OUT leave Z and C unchanged.
  - Arithmetic wraps at DATA_WIDTH bits.
- Jumps: the target overrides the already-incremented pc; a not-taken jump keeps pc+1.
- rd==rs is legal; operands are read before write-back.
- OUT state:
  - out_valid held at 1 and out_data held stable until a cycle with out_ready=1.
  - That cycle: out_valid<=0, go to FETCH.
  - No fetch occurs while in OUT.
- HALT state:
  - halted=1, imem_req=0, pc frozen.
  - Exited only by reset.
- Throughput: minimum 2 cycles per instruction (FETCH with ready in the same cycle, then EXEC). OUT adds at least 1 cycle.

Test Plan:
- Arithmetic and carry, zero-wait memory:
  - Program LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT, with imem_ready tied 1 and out_ready=1.
  - Expected: out_data=8 with a single-cycle out_valid; Z=0, C=0; halted=1 with pc=5.
- Carry wrap:
  - Program LDI r0,0xFF; ADDI r0,1.
  - Expected: r0=0, Z=1, C=1.
  - Then SUB r0 (0) minus r1 (1): r0=0xFF, C=1, Z=0.
- Countdown loop:
  - Program LDI r0,3; LDI r1,1; loop: OUT r0; SUB r0,r1; JZ end; JMP loop; end: HALT.
  - Expected: OUT sequence 3,2,1, then halted=1.
- Wait states and run gating:
  - Insert 0-3 random imem_ready wait cycles and toggle run low mid-fetch.
  - Expected: identical architectural results to the zero-wait run; no ir latch while run=0; imem_addr stable while the request is pending.
- OUT backpressure:
  - Hold out_ready=0 for 4 cycles.
  - Expected: out_valid=1 and out_data stable for all 4; imem_req=0 throughout; exactly one transfer occurs.
- Illegal opcode and reset:
  - Fetch opcode 20.
  - Expected: err=1 and halted=1 on the next cycle.
  - Then assert sys_res mid-stream: all outputs are 0 immediately without waiting for a clock edge, and execution restarts from pc=0.
